// File: rtl/cascade_counter.sv
// Chained modulo counters with carry ripple; stage 0 in the LSBs.
// Optional snapshot register: define COUNTER_SNAPSHOT_EN.
module cascade_counter #(
  parameter int STAGES = 3,
  parameter int WIDTH  = 6,
  // Field value 0 encodes a modulus of 2**WIDTH.
  parameter logic [STAGES*WIDTH-1:0] MODULI = {6'd24, 6'd60, 6'd60}
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  input  logic                    tick_in,
  input  logic                    down_in,
  input  logic                    load_in,
  input  logic [STAGES*WIDTH-1:0] load_value,
  output logic [STAGES*WIDTH-1:0] count,
  output logic [STAGES-1:0]       carry
`ifdef COUNTER_SNAPSHOT_EN
  ,
  input  logic                    snap_in,
  output logic [STAGES*WIDTH-1:0] snap_count
`endif
);

  logic [STAGES*WIDTH-1:0] count_d;
  logic [STAGES-1:0]       carry_d;
  logic [STAGES-1:0]       hit;
  logic [STAGES-1:0]       step;

  if (STAGES < 1) begin : g_bad_stages
    $error("cascade_counter: STAGES must be >= 1");
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_chk
    if (MODULI[g*WIDTH +: WIDTH] == WIDTH'(1)) begin : g_bad_mod
      $error("cascade_counter: modulus of stage %0d below 2", g);
    end
  end

  // Per-stage wrap condition for the current direction.
  always_comb begin
    hit = '0;
    for (int j = 0; j < STAGES; j++) begin
      if (down_in)
        hit[j] = (count[j*WIDTH +: WIDTH] == '0);
      else
        hit[j] = (count[j*WIDTH +: WIDTH] ==
                  MODULI[j*WIDTH +: WIDTH] - WIDTH'(1));
    end
  end

  // Stage i steps when every lower stage is about to wrap.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    step = '0;
    for (int i = 0; i < STAGES; i++) begin
      acc = 1'b1;
      for (int j = 0; j < i; j++)
        acc = acc & hit[j];
      step[i] = acc;
    end
  end

  // Next count/carry: load beats tick beats hold.
  always_comb begin
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] lv;
    logic [WIDTH-1:0] nxt;
    cur     = '0;
    top     = '0;
    lv      = '0;
    nxt     = '0;
    count_d = count;
    carry_d = '0;
    for (int i = 0; i < STAGES; i++) begin
      cur = count[i*WIDTH +: WIDTH];
      top = MODULI[i*WIDTH +: WIDTH] - WIDTH'(1);
      lv  = load_value[i*WIDTH +: WIDTH];
      nxt = cur;
      if (load_in) begin
        nxt = (lv <= top) ? lv : '0;
      end else if (tick_in && step[i]) begin
        if (!down_in) begin
          if (cur == top) begin
            nxt        = '0;
            carry_d[i] = 1'b1;
          end else begin
            nxt = cur + WIDTH'(1);
          end
        end else begin
          if (cur == '0) begin
            nxt        = top;
            carry_d[i] = 1'b1;
          end else begin
            nxt = cur - WIDTH'(1);
          end
        end
      end
      count_d[i*WIDTH +: WIDTH] = nxt;
    end
  end

  // Count and carry registers.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      carry <= '0;
    end else begin
      count <= count_d;
      carry <= carry_d;
    end
  end

`ifdef COUNTER_SNAPSHOT_EN
  // Capture the pre-update count for a tear-free read.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)
      snap_count <= '0;
    else if (snap_in)
      snap_count <= count;
  end
`endif

endmodule
